// File: rtl/cnt5_pkg.sv
// Shared definitions for the 5-way counter family: state encoding, default sizes and wrap helpers.
package cnt5_pkg;

    localparam int MOD_DEFAULT = 5;
    localparam int CW_DEFAULT  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERR   = 2'b10
    } cnt5_state_e;

    // Modular neighbours of p within 0..m-1.
    function automatic int wrapUp(input int p, input int m);
        return (p == m - 1) ? 0 : p + 1;
    endfunction

    function automatic int wrapDn(input int p, input int m);
        return (p == 0) ? m - 1 : p - 1;
    endfunction

endpackage

// File: rtl/cnt5_step_cls.sv
// Combinational classifier: relates a new count sample to the previously accepted one.
module cnt5_step_cls
    import cnt5_pkg::*;
#(
    parameter int MOD = MOD_DEFAULT,
    parameter int CW  = CW_DEFAULT
) (
    input  logic [CW-1:0] prev_i,
    input  logic [CW-1:0] cnt_i,
    output logic          is_up_o,
    output logic          is_dn_o,
    output logic          is_hold_o,
    output logic          is_bad_o
);

    logic legal;

    assign legal     = int'(cnt_i) < MOD;
    assign is_up_o   = legal && (int'(cnt_i) == wrapUp(int'(prev_i), MOD));
    assign is_dn_o   = legal && (int'(cnt_i) == wrapDn(int'(prev_i), MOD));
    assign is_hold_o = legal && (cnt_i == prev_i);
    assign is_bad_o  = !(is_up_o || is_dn_o || is_hold_o);

endmodule

// File: rtl/cnt5_tracker.sv
// Recovers up/down/hold intent from an observed counter bus and flags illegal jumps.
// Optional signed net-step output tally is enabled by CNT5_TRACKER_TALLY_EN.
module cnt5_tracker
    import cnt5_pkg::*;
#(
    parameter int MOD = MOD_DEFAULT,
    parameter int CW  = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] cnt,
    input  logic          clr,
    output logic          step,
    output logic          dir,
    output logic          locked,
    output logic          err
`ifdef CNT5_TRACKER_TALLY_EN
   ,output logic [7:0]    tally
`endif
);

    cnt5_state_e   state_q, state_d;
    logic [CW-1:0] prev_q, prev_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic          is_up, is_dn, is_hold, is_bad;
    logic          cnt_legal;
`ifdef CNT5_TRACKER_TALLY_EN
    logic [7:0]    tally_q, tally_d;
`endif

    cnt5_step_cls #(.MOD(MOD), .CW(CW)) u_cls (
        .prev_i    (prev_q),
        .cnt_i     (cnt),
        .is_up_o   (is_up),
        .is_dn_o   (is_dn),
        .is_hold_o (is_hold),
        .is_bad_o  (is_bad)
    );

    assign cnt_legal = int'(cnt) < MOD;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        locked_d = locked_q;
        err_d    = err_q;
`ifdef CNT5_TRACKER_TALLY_EN
        tally_d  = tally_q;
`endif
        // clr overrides any classification of the current sample.
        if (clr) begin
            state_d  = IDLE;
            dir_d    = 1'b0;
            locked_d = 1'b0;
            err_d    = 1'b0;
`ifdef CNT5_TRACKER_TALLY_EN
            tally_d  = 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_legal) begin
                        prev_d   = cnt;
                        state_d  = TRACK;
                        locked_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (is_bad) begin
                        state_d  = ERR;
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                    end else if (!is_hold) begin
                        step_d = 1'b1;
                        dir_d  = is_up;
                        prev_d = cnt;
`ifdef CNT5_TRACKER_TALLY_EN
                        tally_d = is_dn ? tally_q - 8'd1 : tally_q + 8'd1;
`endif
                    end
                end
                ERR: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

`ifdef CNT5_TRACKER_TALLY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tally_q <= 8'd0;
        else          tally_q <= tally_d;
    end

    assign tally = tally_q;
`endif

    assign step   = step_q;
    assign dir    = dir_q;
    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_cnt5_tracker.sv
// Scoreboard bench for cnt5_tracker: directed samples push expected outputs, a monitor compares.
module tb_cnt5_tracker;
    import cnt5_pkg::*;

    typedef struct {
        string      name;
        logic [11:0] expVal;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] cnt = 3'd0;
    logic       clr = 1'b0;
    logic       step, dir, locked, err;
    logic [7:0] tallyAct;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       sb[$];

`ifdef CNT5_TRACKER_TALLY_EN
    logic [7:0] tally;
    assign tallyAct = tally;
`else
    assign tallyAct = 8'd0;
`endif

    cnt5_tracker dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cnt     (cnt),
        .clr     (clr),
        .step    (step),
        .dir     (dir),
        .locked  (locked),
        .err     (err)
`ifdef CNT5_TRACKER_TALLY_EN
       ,.tally   (tally)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pack(input logic s, input logic d, input logic l,
                                         input logic e, input logic [7:0] t);
`ifdef CNT5_TRACKER_TALLY_EN
        return {s, d, l, e, t};
`else
        return {s, d, l, e, 8'd0};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [11:0] expVal);
        logic [11:0] act;
        act = {step, dir, locked, err, tallyAct};
        vectors++;
        if (act !== expVal) begin
            miscompares++;
            $display("[TB] FAIL %s: got step/dir/locked/err=%b tally=%0d, expected step/dir/locked/err=%b tally=%0d",
                     name, act[11:8], act[7:0], expVal[11:8], expVal[7:0]);
        end
    endtask

    // Drive one sample for the next rising edge and record what should appear after it.
    task automatic applyStimulus(input string name, input logic [2:0] c, input logic cl,
                                 input logic s, input logic d, input logic l,
                                 input logic e, input logic [7:0] t);
        exp_t item;
        @(negedge clk);
        cnt = c;
        clr = cl;
        @(posedge clk);
        item.name   = name;
        item.expVal = pack(s, d, l, e, t);
        sb.push_back(item);
    endtask

    initial begin : monitor
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                item = sb.pop_front();
                checkOutput(item.name, item.expVal);
            end
        end
    end

    initial begin : stimulus
        int budget;
        #12;
        checkOutput("reset_state", pack(0, 0, 0, 0, 8'd0));
        @(negedge clk);
        reset_n = 1'b1;

        // Up run with 4->0 wrap
        applyStimulus("lock0",   3'd0, 0, 0, 0, 1, 0, 8'd0);
        applyStimulus("up1",     3'd1, 0, 1, 1, 1, 0, 8'd1);
        applyStimulus("up2",     3'd2, 0, 1, 1, 1, 0, 8'd2);
        applyStimulus("up3",     3'd3, 0, 1, 1, 1, 0, 8'd3);
        applyStimulus("up4",     3'd4, 0, 1, 1, 1, 0, 8'd4);
        applyStimulus("upwrap0", 3'd0, 0, 1, 1, 1, 0, 8'd5);
        applyStimulus("up1b",    3'd1, 0, 1, 1, 1, 0, 8'd6);
        applyStimulus("up2b",    3'd2, 0, 1, 1, 1, 0, 8'd7);

        // Down run with 0->4 wrap
        applyStimulus("dn1",     3'd1, 0, 1, 0, 1, 0, 8'd6);
        applyStimulus("dn0",     3'd0, 0, 1, 0, 1, 0, 8'd5);
        applyStimulus("dnwrap4", 3'd4, 0, 1, 0, 1, 0, 8'd4);
        applyStimulus("dn3",     3'd3, 0, 1, 0, 1, 0, 8'd3);

        // Hold at 3 after an up step: dir stays 1
        applyStimulus("dn2",     3'd2, 0, 1, 0, 1, 0, 8'd2);
        applyStimulus("up3c",    3'd3, 0, 1, 1, 1, 0, 8'd3);
        for (int i = 0; i < 4; i++)
            applyStimulus("hold3", 3'd3, 0, 0, 1, 1, 0, 8'd3);

        // Illegal jump 1->3, ERR ignores cnt, clr recovers
        applyStimulus("dn2d",    3'd2, 0, 1, 0, 1, 0, 8'd2);
        applyStimulus("dn1d",    3'd1, 0, 1, 0, 1, 0, 8'd1);
        applyStimulus("jump3",   3'd3, 0, 0, 0, 0, 1, 8'd1);
        applyStimulus("errhold", 3'd2, 0, 0, 0, 0, 1, 8'd1);
        applyStimulus("clr",     3'd2, 1, 0, 0, 0, 0, 8'd0);
        applyStimulus("relock2", 3'd2, 0, 0, 0, 1, 0, 8'd0);

        // Out-of-range from TRACK, clr beats illegal cnt, illegal in IDLE
        applyStimulus("up3e",    3'd3, 0, 1, 1, 1, 0, 8'd1);
        applyStimulus("up4e",    3'd4, 0, 1, 1, 1, 0, 8'd2);
        applyStimulus("range6",  3'd6, 0, 0, 1, 0, 1, 8'd2);
        applyStimulus("clrbad6", 3'd6, 1, 0, 0, 0, 0, 8'd0);
        applyStimulus("idle7a",  3'd7, 0, 0, 0, 0, 0, 8'd0);
        applyStimulus("idle7b",  3'd7, 0, 0, 0, 0, 0, 8'd0);

        // Asynchronous reset between edges
        applyStimulus("lock3",   3'd3, 0, 0, 0, 1, 0, 8'd0);
        applyStimulus("up4f",    3'd4, 0, 1, 1, 1, 0, 8'd1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 checkOutput("async_reset", pack(0, 0, 0, 0, 8'd0));
        #1 reset_n = 1'b1;
        applyStimulus("postrst_lock4", 3'd4, 0, 0, 0, 1, 0, 8'd0);
        applyStimulus("postrst_up0",   3'd0, 0, 1, 1, 1, 0, 8'd1);

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
